// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the clk_divider block.
//   state_t   - divider control states (IDLE, RUN, STOP)
//   MIN_DIV   - smallest divisor the block will run with
//   clamp_div - raises divisor requests below MIN_DIV to MIN_DIV
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/clk_divider.sv
// clk_divider: programmable integer clock divider feeding the clock buffer.
//
// Produces a registered divided clock (div_clk) from mclk with a period of
// exactly N mclk cycles: N - floor(N/2) cycles high, floor(N/2) cycles low.
// Start and stop are glitch-free, and divisor changes take effect only at
// period boundaries.
//
// Ports:
//   mclk     in   master clock, all logic on posedge
//   rst_n    in   synchronous active-low reset
//   en       in   run request (level)
//   div_val  in   requested divisor, 0/1 clamped to 2
//   div_load in   strobe capturing div_val into the shadow register
//   sync_req in   (CLKDIV_SYNC_EN only) restart the period at the next edge
//   div_clk  out  divided clock
//   tick     out  one-cycle pulse in the cycle div_clk rises
//   busy     out  high whenever the divider is not idle
//   div_act  out  divisor currently in effect
//
// Build option: define CLKDIV_SYNC_EN to add the sync_req phase-align input.
module clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 4
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_req,
`endif
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] div_act
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RST);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             clk_d, tick_d;

  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] cnt_nxt;
  logic             last;
  logic             boundary;
  logic             sync_hit;

  // High phase is the larger half so odd divisors favour high.
  assign hi      = div_act - (div_act >> 1);
  assign last    = (cnt_q == div_act - 1'b1);
  assign cnt_nxt = last ? '0 : cnt_q + 1'b1;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_req;
`else
  assign sync_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_d    = div_clk;
    tick_d   = 1'b0;
    act_d    = div_act;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    boundary = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Every idle edge is a boundary, so a pending load lands at once.
        boundary = 1'b1;
        cnt_d    = '0;
        if (en) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end else begin
          clk_d   = 1'b0;
        end
      end
      RUN, STOP: begin
        if (sync_hit) begin
          boundary = 1'b1;
          cnt_d    = '0;
          clk_d    = 1'b1;
          tick_d   = 1'b1;
          state_d  = en ? RUN : STOP;
        end else if (!en && last) begin
          boundary = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
          clk_d    = 1'b0;
        end else begin
          // STOP keeps counting; it only differs from RUN in that the
          // period end drops to IDLE instead of wrapping.
          boundary = last;
          cnt_d    = cnt_nxt;
          clk_d    = (cnt_nxt < hi);
          tick_d   = last;
          state_d  = en ? RUN : STOP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    if (boundary && pend_q) begin
      act_d  = shadow_q;
      pend_d = 1'b0;
    end

    // A load on a boundary edge is captured for the following boundary.
    if (div_load) begin
      shadow_d = DIV_W'(clamp_div(32'(div_val)));
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_clk  <= 1'b0;
      tick     <= 1'b0;
      div_act  <= RST_DIV;
      shadow_q <= RST_DIV;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_clk  <= clk_d;
      tick     <= tick_d;
      div_act  <= act_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: scoreboard bench for clk_divider.
// The reference model thinks in whole periods: at each period start it
// queues the N-cycle high/low waveform and plays it out; divisor loads and
// stop requests only matter when that waveform runs dry.
module tb_clk_divider;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DIV_RST = 4;

  logic             mclk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
`ifdef CLKDIV_SYNC_EN
  logic             sync_req = 1'b0;
`endif
  logic             div_clk;
  logic             tick;
  logic             busy;
  logic [DIV_W-1:0] div_act;

  clk_divider #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
    .mclk     (mclk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
`ifdef CLKDIV_SYNC_EN
    .sync_req (sync_req),
`endif
    .div_clk  (div_clk),
    .tick     (tick),
    .busy     (busy),
    .div_act  (div_act)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    bit clk;
    bit tick;
    bit busy;
    int act;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  bit running = 0;
  bit wave_q[$];
  int m_act = DIV_RST;
  int m_shadow = DIV_RST;
  bit m_pend = 0;

  function automatic void start_period(output bit first);
    int n;
    n = m_act;
    wave_q.delete();
    for (int i = 0; i < n; i++) wave_q.push_back(i < (n - n / 2));
    first = wave_q.pop_front();
  endfunction

  task automatic model_edge(output exp_t e);
    bit c;
    bit t;
    c = 0;
    t = 0;
    if (!rst_n) begin
      running = 0;
      wave_q.delete();
      m_act = DIV_RST;
      m_shadow = DIV_RST;
      m_pend = 0;
    end else begin
      if (running && wave_q.size() > 0) begin
        c = wave_q.pop_front();
      end else begin
        if (m_pend) begin
          m_act = m_shadow;
          m_pend = 0;
        end
        if (en) begin
          start_period(c);
          t = 1;
          running = 1;
        end else begin
          running = 0;
        end
      end
      if (div_load) begin
        m_shadow = (int'(div_val) < 2) ? 2 : int'(div_val);
        m_pend = 1;
      end
    end
    e.clk = c;
    e.tick = t;
    e.busy = running;
    e.act = m_act;
  endtask

  task automatic cyc(input bit r, input bit e, input bit l, input int v);
    exp_t x;
    rst_n = r;
    en = e;
    div_load = l;
    div_val = DIV_W'(v);
    @(posedge mclk);
    model_edge(x);
    exp_q.push_back(x);
    @(negedge mclk);
  endtask

  // Monitor: the DUT presents a fresh output set after every edge.
  always @(negedge mclk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      tests += 4;
      if (div_clk !== x.clk) begin
        fails++;
        $display("FAIL div_clk @%0t: got %b exp %b", $time, div_clk, x.clk);
      end
      if (tick !== x.tick) begin
        fails++;
        $display("FAIL tick @%0t: got %b exp %b", $time, tick, x.tick);
      end
      if (busy !== x.busy) begin
        fails++;
        $display("FAIL busy @%0t: got %b exp %b", $time, busy, x.busy);
      end
      if (div_act !== DIV_W'(x.act)) begin
        fails++;
        $display("FAIL div_act @%0t: got %0d exp %0d", $time, div_act, x.act);
      end
    end
  end

  initial begin
    rst_n = 0;
    en = 0;
    div_load = 0;
    div_val = '0;
    @(negedge mclk);

    // Reset, then run at the reset divisor.
    repeat (3) cyc(0, 0, 0, 0);
    repeat (13) cyc(1, 1, 0, 0);
    // Mid-period load of 3.
    cyc(1, 1, 1, 3);
    repeat (14) cyc(1, 1, 0, 0);
    // Load 0 clamps to 2, then 1 clamps to 2 as well.
    cyc(1, 1, 1, 0);
    repeat (8) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    repeat (4) cyc(1, 1, 0, 0);
    // Divisor 6: stop, re-enable during STOP, then stop to idle.
    cyc(1, 1, 1, 6);
    repeat (9) cyc(1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    repeat (8) cyc(1, 1, 0, 0);
    repeat (12) cyc(1, 0, 0, 0);
    // Load while idle, double load (last wins), then run.
    cyc(1, 0, 1, 5);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 9);
    cyc(1, 0, 1, 7);
    repeat (16) cyc(1, 1, 0, 0);
    // Reset while running with en held high.
    repeat (3) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (10) cyc(1, 1, 0, 0);
    // Maximum divisor for one full period.
    cyc(1, 1, 1, 255);
    repeat (520) cyc(1, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit e;
      bit l;
      int v;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                      : int'($urandom_range(0, 9));
      cyc(r, e, l, v);
    end
    repeat (300) cyc(1, 0, 0, 0);

    @(negedge mclk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
